// File: rtl/fbuf_video_pkg.sv
// Shared video timing defaults, frame-size helpers and the control word that
// travels alongside pixel reads through the BRAM latency pipeline.
package fbuf_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } video_ctrl_t;

    localparam video_ctrl_t CTRL_IDLE = '0;

    typedef enum logic {
        ST_STOPPED,
        ST_RUNNING
    } run_state_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/fbuf_scanout_reader_if.sv
// Framebuffer read port plus the video output bundle of the scanout reader.
interface fbuf_scanout_reader_if #(
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int FBUF_DATA_WIDTH = 8
);
    logic                       fbuf_en_rd;
    logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr;
    logic [FBUF_DATA_WIDTH-1:0] fbuf_data_in;
    logic [FBUF_DATA_WIDTH-1:0] pix_data;
    logic                       pix_de;
    logic                       pix_hsync;
    logic                       pix_vsync;
    logic                       frame_start;

    modport master (
        output fbuf_en_rd, fbuf_addr, pix_data, pix_de, pix_hsync, pix_vsync, frame_start,
        input  fbuf_data_in
    );

    modport slave (
        input  fbuf_en_rd, fbuf_addr, pix_data, pix_de, pix_hsync, pix_vsync, frame_start,
        output fbuf_data_in
    );
endinterface

// File: rtl/fbuf_scanout_reader_video_timing_gen.sv
// Raster timing generator: h/v counters, frame-granular run control and the
// registered stage-0 flags (de/hs/vs/fs, all forced idle while stopped).
module video_timing_gen
    import fbuf_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output video_ctrl_t ctrl,
    output logic        fs_next,
    output logic        run_next,
    output logic        running
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    run_state_t    state, state_nx;
    logic [HW-1:0] h, h_nx;
    logic [VW-1:0] v, v_nx;
    video_ctrl_t   ctrl_nx;
    logic          line_end;
    logic          frame_end;

    // Enable is only honoured while stopped or on the very last clk of a frame.
    always_comb begin
        line_end  = (h == HW'(H_TOTAL - 1));
        frame_end = line_end && (v == VW'(V_TOTAL - 1));
        state_nx  = state;
        h_nx      = h;
        v_nx      = v;
        case (state)
            ST_STOPPED: begin
                h_nx = '0;
                v_nx = '0;
                if (enable) state_nx = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (frame_end) begin
                    h_nx = '0;
                    v_nx = '0;
                    if (!enable) state_nx = ST_STOPPED;
                end else if (line_end) begin
                    h_nx = '0;
                    v_nx = v + 1'b1;
                end else begin
                    h_nx = h + 1'b1;
                end
            end
            default: state_nx = ST_STOPPED;
        endcase

        ctrl_nx = CTRL_IDLE;
        if (state_nx == ST_RUNNING) begin
            ctrl_nx.de = (h_nx < HW'(H_ACTIVE)) && (v_nx < VW'(V_ACTIVE));
            ctrl_nx.hs = (h_nx >= HW'(H_ACTIVE + H_FP)) && (h_nx < HW'(H_ACTIVE + H_FP + H_SYNC));
            ctrl_nx.vs = (v_nx >= VW'(V_ACTIVE + V_FP)) && (v_nx < VW'(V_ACTIVE + V_FP + V_SYNC));
            ctrl_nx.fs = (h_nx == '0) && (v_nx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_STOPPED;
            h     <= '0;
            v     <= '0;
            ctrl  <= CTRL_IDLE;
        end else begin
            state <= state_nx;
            h     <= h_nx;
            v     <= v_nx;
            ctrl  <= ctrl_nx;
        end
    end

    assign fs_next  = ctrl_nx.fs;
    assign run_next = (state_nx == ST_RUNNING);
    assign running  = (state == ST_RUNNING);

endmodule

// File: rtl/fbuf_scanout_reader.sv
// Framebuffer scanout: raster timing, linear read addressing and alignment of
// the sync/de flags with BRAM read data before it leaves for the video encoder.
module fbuf_scanout_reader
    import fbuf_video_pkg::*;
#(
    parameter int FBUF_ADDR_WIDTH  = 19,
    parameter int FBUF_DATA_WIDTH  = 8,
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FP             = DEF_H_FP,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BP             = DEF_H_BP,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FP             = DEF_V_FP,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BP             = DEF_V_BP,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int BRAM_LATENCY     = 2
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  running,
    fbuf_scanout_reader_if.master bus
);
    if (H_ACTIVE * V_ACTIVE > 2 ** FBUF_ADDR_WIDTH) begin : g_addr_range_check
        $error("fbuf_scanout_reader: H_ACTIVE*V_ACTIVE exceeds FBUF_ADDR_WIDTH");
    end
    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 3) begin : g_latency_check
        $error("fbuf_scanout_reader: BRAM_LATENCY must be 1..3");
    end

    localparam logic SYNC_INV = (SYNC_ACTIVE_HIGH == 0);

    video_ctrl_t                stage0;
    video_ctrl_t                ctrl_pipe [1:BRAM_LATENCY];
    video_ctrl_t                ctrl_out;
    logic                       fs_next;
    logic                       run_next;
    logic [FBUF_ADDR_WIDTH-1:0] pix_addr;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .ctrl     (stage0),
        .fs_next  (fs_next),
        .run_next (run_next),
        .running  (running)
    );

    // Address advances after every active pixel so it tracks stage 0 without a multiplier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_addr <= '0;
            for (int i = 1; i <= BRAM_LATENCY; i++) ctrl_pipe[i] <= CTRL_IDLE;
        end else begin
            if (fs_next || !run_next) pix_addr <= '0;
            else if (stage0.de)       pix_addr <= pix_addr + 1'b1;
            ctrl_pipe[1] <= stage0;
            for (int i = 2; i <= BRAM_LATENCY; i++) ctrl_pipe[i] <= ctrl_pipe[i-1];
        end
    end

    assign ctrl_out        = ctrl_pipe[BRAM_LATENCY];
    assign bus.fbuf_en_rd  = stage0.de;
    assign bus.fbuf_addr   = pix_addr;
    assign bus.pix_de      = ctrl_out.de;
    assign bus.pix_hsync   = ctrl_out.hs ^ SYNC_INV;
    assign bus.pix_vsync   = ctrl_out.vs ^ SYNC_INV;
    assign bus.frame_start = ctrl_out.fs;
    assign bus.pix_data    = ctrl_out.de ? bus.fbuf_data_in : '0;

endmodule

// File: tb/tb_fbuf_scanout_reader.sv
// Scanout reader bench: three DUTs (BRAM latency 1, 2, 3) on a reduced raster,
// random enable/reset stimulus, every output compared each clk to a frame-time model.
module tb_fbuf_scanout_reader;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 3;
    localparam int HB    = 3;
    localparam int VA    = 6;
    localparam int VFP   = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int HT    = HA + HFP + HS + HB;
    localparam int VT    = VA + VFP + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        bit de;
        bit hs;
        bit vs;
        bit fs;
        int idx;
    } expCtrl_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    bit            checkOn = 1'b0;
    int            testsRun = 0;
    int            testsFailed = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    bit            mRun = 1'b0;
    int            mT = 0;
    expCtrl_t      hist [0:3] = '{default: '0};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic enVal, input int cycles);
        rst_n  = rstVal;
        enable = enVal;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    // Expected stage-0 view of frame time t: position comes straight from t.
    function automatic expCtrl_t frameRef(input bit run, input int t);
        expCtrl_t r;
        int h;
        int v;
        h     = t % HT;
        v     = t / HT;
        r.de  = run && (h < HA) && (v < VA);
        r.hs  = run && (h >= HA + HFP) && (h < HA + HFP + HS);
        r.vs  = run && (v >= VA + VFP) && (v < VA + VFP + VS);
        r.fs  = run && (t == 0);
        r.idx = v * HA + h;
        return r;
    endfunction

    // Frame-level behaviour: whole frames only, enable looked at between frames.
    always @(posedge clk) begin
        if (!rst_n) begin
            mRun = 1'b0;
            mT   = 0;
        end else if (!mRun) begin
            if (enable) begin
                mRun = 1'b1;
                mT   = 0;
            end
        end else if (mT == FRAME - 1) begin
            mT = 0;
            if (!enable) mRun = 1'b0;
        end else begin
            mT++;
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = frameRef(mRun, mT);
        if (!rst_n) for (int i = 0; i < 4; i++) hist[i] = '0;
    end

    for (genvar g = 1; g <= 3; g++) begin : lat
        fbuf_scanout_reader_if #(.FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW)) bus ();
        logic          running;
        logic [DW-1:0] rdPipe [1:3];

        fbuf_scanout_reader #(
            .FBUF_ADDR_WIDTH (AW), .FBUF_DATA_WIDTH (DW),
            .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
            .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
            .SYNC_ACTIVE_HIGH (0), .BRAM_LATENCY (g)
        ) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .running (running),
            .bus     (bus)
        );

        always @(posedge clk) begin
            rdPipe[1] <= mem[bus.fbuf_addr];
            rdPipe[2] <= rdPipe[1];
            rdPipe[3] <= rdPipe[2];
        end
        assign bus.fbuf_data_in = rdPipe[g];

        always @(negedge clk) begin
            if (checkOn) begin
                checkOutput($sformatf("L%0d running", g), 32'(running), 32'(mRun));
                checkOutput($sformatf("L%0d fbuf_en_rd", g), 32'(bus.fbuf_en_rd), 32'(hist[0].de));
                if (hist[0].de)
                    checkOutput($sformatf("L%0d fbuf_addr", g), 32'(bus.fbuf_addr), 32'(hist[0].idx));
                if (!mRun)
                    checkOutput($sformatf("L%0d idle fbuf_addr", g), 32'(bus.fbuf_addr), 32'd0);
                checkOutput($sformatf("L%0d pix_de", g), 32'(bus.pix_de), 32'(hist[g].de));
                checkOutput($sformatf("L%0d pix_hsync", g), 32'(bus.pix_hsync), 32'(!hist[g].hs));
                checkOutput($sformatf("L%0d pix_vsync", g), 32'(bus.pix_vsync), 32'(!hist[g].vs));
                checkOutput($sformatf("L%0d frame_start", g), 32'(bus.frame_start), 32'(hist[g].fs));
                checkOutput($sformatf("L%0d pix_data", g), 32'(bus.pix_data),
                            hist[g].de ? 32'(mem[hist[g].idx]) : 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        rst_n  = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #2;
        checkOn = 1'b1;

        // Reset held with enable high, then an idle gap before the first start.
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b0, 3);

        // Continuous frames with a short mid-frame enable drop that must not stop scanout.
        applyStimulus(1'b1, 1'b1, FRAME + $urandom_range(40, 150));
        applyStimulus(1'b1, 1'b0, $urandom_range(2, 10));
        applyStimulus(1'b1, 1'b1, FRAME);

        // Stop part-way through a frame, let it complete and drain, then restart.
        applyStimulus(1'b1, 1'b0, FRAME + 20);
        applyStimulus(1'b1, 1'b1, FRAME + $urandom_range(50, 180));

        // Reset mid-frame, then restart from address 0.
        applyStimulus(1'b0, 1'b1, $urandom_range(1, 3));
        applyStimulus(1'b1, 1'b1, 2 * FRAME);

        for (int k = 0; k < 12; k++)
            applyStimulus(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
                          $urandom_range(1, 300));

        applyStimulus(1'b1, 1'b0, FRAME + 10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fbuf_scanout_reader.md
Name: fbuf_scanout_reader

Overview:
- Read-side counterpart of the GPU framebuffer write path.
- Generates 640x480@60 raster timing and reads the framebuffer BRAM through its read port, one pixel per clk.
- Emits pixel data with aligned de/hsync/vsync to the downstream video encoder (DVI/HDMI TX).
- Sits between the framebuffer BRAM port B and the video output path. clk is the pixel clock.

Parameters:
- FBUF_ADDR_WIDTH, 19, framebuffer address width (linear pixel index).
- FBUF_DATA_WIDTH, 8, pixel width.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch (clk).
- H_SYNC, 96, hsync width (clk).
- H_BP, 48, horizontal back porch (clk).
- V_ACTIVE, 480, active lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_ACTIVE_HIGH, 0, sync polarity (0 = active-low).
- BRAM_LATENCY, 2, read latency in clk from address to data; legal range 1..3.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  scanout run request
- fbuf_en_rd  out  1  BRAM read enable
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM read address
- fbuf_data_in  in  FBUF_DATA_WIDTH  BRAM read data, valid BRAM_LATENCY clk after address
- pix_data  out  FBUF_DATA_WIDTH  output pixel
- pix_de  out  1  active-video flag
- pix_hsync  out  1  horizontal sync
- pix_vsync  out  1  vertical sync
- frame_start  out  1  one-clk pulse, coincident with output pixel (0,0)
- running  out  1  timing generator active

Behaviour:
- Reset is synchronous, active-low on rst_n, clock clk.
- Reset state:
  - h/v counters = 0; running = 0; fbuf_en_rd = 0; fbuf_addr = 0.
  - pix_de = 0; pix_data = 0; frame_start = 0.
  - Syncs at inactive level (1 when SYNC_ACTIVE_HIGH = 0).
  - Pipeline stages are cleared to the same idle values.
  - Reset mid-frame takes effect on the next edge; there is no drain.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Stopped state:
  - Counters are held at 0.
  - If enable is sampled high, running = 1 from the next clk, and that clk is h = 0, v = 0.
- Running state:
  - h increments every clk and wraps at H_TOTAL-1; v increments on h wrap and wraps at V_TOTAL-1.
  - On the cycle h = H_TOTAL-1, v = V_TOTAL-1, enable is sampled. If low, the block goes to stopped next clk; if high, the next frame starts with no gap.
  - Mid-frame deassertion of enable has no effect until the frame ends.
- Stage 0 (timing):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - fs = (h == 0 && v == 0 && running).
- Addressing:
  - fbuf_en_rd = active; fbuf_addr = linear pixel counter, registered with stage 0.
  - The counter clears to 0 at frame start and increments after each active pixel.
  - It runs 0..H_ACTIVE*V_ACTIVE-1 (0..307199), using no multiplier.
  - Address is held (not incremented) during blanking.
- Alignment:
  - {active, hs, vs, fs} are delayed BRAM_LATENCY stages.
  - pix_de, pix_hsync, pix_vsync, frame_start and pix_data are updated on the same edge as fbuf_data_in becomes valid.
  - pix_data = fbuf_data_in when the delayed active is 1, else 0.
- Syncs are driven with polarity applied: inactive level when deasserted, active level when asserted.
- Stop: stage 0 emits idle values, and in-flight stages drain normally over BRAM_LATENCY clk.
- Width rules:
  - Counters are sized $clog2(H_TOTAL) and $clog2(V_TOTAL).
  - Elaboration error if H_ACTIVE*V_ACTIVE > 2**FBUF_ADDR_WIDTH or BRAM_LATENCY is outside 1..3.

Decomposition:
- Package fbuf_video_pkg holds:
  - Default 640x480 timing localparams and H_TOTAL/V_TOTAL functions.
  - A packed struct video_ctrl_t {de, hs, vs, fs} used for the delay pipeline.
- One sub-module: video_timing_gen. It contains the counters, enable/run logic and stage-0 flags, and is reused by future overlay blocks.
- The address counter, latency pipeline and output mux stay in fbuf_scanout_reader.

Test Plan:
- Reset: hold rst_n = 0 for 5 clk with enable = 1 -> outputs at idle values; pix_hsync = 1, pix_vsync = 1, all others 0.
- Start, BRAM_LATENCY = 2, BRAM model with mem[a] = a[7:0]:
  - enable high at cycle T -> fbuf_en_rd = 1 and fbuf_addr = 0 at T+1.
  - pix_de = 1, pix_data = 0x00 and frame_start = 1 at T+3.
  - pix_data = 0x01 at T+4.
- Line timing:
  - pix_de high 640 clk, then low 160 clk.
  - pix_hsync low for exactly 96 clk, starting 656 clk after pix_de rise; line period 800 clk.
- Frame:
  - pix_vsync low for 2 lines starting at line 490; frame period 420000 clk.
  - Last active address 307199, then 0 at the next frame's first pixel; frame_start pulses exactly once per frame.
- Stop: deassert enable at line 100 -> the frame completes. running = 0 after cycle 419999. The pipeline drains 2 clk, then outputs are idle; reasserting enable restarts at (0,0).
- Latency sweep with BRAM_LATENCY = 1 and 3 -> pix_data matches mem at every pix_de cycle, and sync/de edges shift by exactly the latency.
- Reset mid-frame at line 200 -> outputs are idle on the next edge. Restart with enable begins at address 0.
